// File: rtl/f_to_d_queue_pkg.sv
// pipe_pkg: shared fetch-to-decode types and constants.
//   XLEN/PC_BITS/DEPTH : default widths and queue depth
//   NOP_INST           : instruction shown on decode when nothing is valid
//   fd_entry_t         : one queued {pc, inst} pair
package pipe_pkg;
   localparam int XLEN    = 32;
   localparam int PC_BITS = 5;
   localparam int DEPTH   = 4;
   localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;
   typedef struct packed {
      logic [PC_BITS-1:0] pc;
      logic [XLEN-1:0]    inst;
   } fd_entry_t;
endpackage

// File: rtl/f_to_d_queue_if.sv
// f_to_d_queue_if: fetch/decode handshake bundle for the f_to_d_queue.
//   flush              : discard everything in flight
//   F_valid/F_pc/F_inst/F_ready : fetch-side valid/ready push port
//   stall_D            : decode back-pressure (inverted ready)
//   D_valid/D_pc/D_inst : decode-side head entry
//   count              : current occupancy
//   master : fetch/decode pipeline side; slave : the queue
interface f_to_d_queue_if
   import pipe_pkg::*;
#(
   parameter int XLEN    = pipe_pkg::XLEN,
   parameter int PC_BITS = pipe_pkg::PC_BITS,
   parameter int DEPTH   = pipe_pkg::DEPTH
);
   logic                         flush;
   logic                         F_valid;
   logic [PC_BITS-1:0]           F_pc;
   logic [XLEN-1:0]              F_inst;
   logic                         F_ready;
   logic                         stall_D;
   logic                         D_valid;
   logic [PC_BITS-1:0]           D_pc;
   logic [XLEN-1:0]              D_inst;
   logic [$clog2(DEPTH+1)-1:0]   count;
   modport master (
      output flush, F_valid, F_pc, F_inst, stall_D,
      input  F_ready, D_valid, D_pc, D_inst, count
   );
   modport slave (
      input  flush, F_valid, F_pc, F_inst, stall_D,
      output F_ready, D_valid, D_pc, D_inst, count
   );
endinterface

// File: rtl/f_to_d_queue_mem.sv
// fd_queue_mem: DEPTH x W register array, one write port, one async read port.
//   clk : write clock
//   we/wa/wd : write enable, address, data
//   ra/rd    : combinational read address, data
// Contents are deliberately not reset; validity is tracked by the controller.
module fd_queue_mem #(
   parameter int DEPTH = 4,
   parameter int W     = 37,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [W-1:0]  wd,
   input  logic [AW-1:0] ra,
   output logic [W-1:0]  rd
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[wa] <= wd;
   assign rd = mem[ra];
endmodule

// File: rtl/f_to_d_queue.sv
// f_to_d_queue: DEPTH-entry FIFO of {pc, inst} between fetch and decode.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset of pointers and count
//   q     : slave side of f_to_d_queue_if (fetch push, decode pop, flush, count)
// F_ready depends only on registered occupancy, so a full queue refuses fetch
// even in a cycle where decode pops. Flush wins over any push/pop that cycle.
module f_to_d_queue
   import pipe_pkg::*;
#(
   parameter int                XLEN     = pipe_pkg::XLEN,
   parameter int                PC_BITS  = pipe_pkg::PC_BITS,
   parameter int                DEPTH    = pipe_pkg::DEPTH,
   parameter logic [XLEN-1:0]   NOP_INST = pipe_pkg::NOP_INST
) (
   input logic          clk,
   input logic          rst_n,
   f_to_d_queue_if.slave q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int W  = PC_BITS + XLEN;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] cnt;
   logic [W-1:0]  head;
   logic          push, pop;
   assign q.F_ready = cnt != CW'(DEPTH);
   assign q.D_valid = cnt != '0;
   assign push      = q.F_valid & q.F_ready;
   assign pop       = q.D_valid & ~q.stall_D;
   assign q.count   = cnt;
   assign q.D_pc    = q.D_valid ? head[W-1:XLEN] : '0;
   assign q.D_inst  = q.D_valid ? head[XLEN-1:0] : NOP_INST;
   fd_queue_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
      .clk (clk),
      .we  (push & ~q.flush),
      .wa  (wr_ptr),
      .wd  ({q.F_pc, q.F_inst}),
      .ra  (rd_ptr),
      .rd  (head)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (q.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push & ~pop) cnt <= cnt + CW'(1);
         else if (pop & ~push) cnt <= cnt - CW'(1);
      end
   a_count_max: assert property (@(posedge clk) disable iff (!rst_n) cnt <= CW'(DEPTH));
   a_no_over:   assert property (@(posedge clk) disable iff (!rst_n) !(push && cnt == CW'(DEPTH)));
   a_no_under:  assert property (@(posedge clk) disable iff (!rst_n) !(pop && cnt == '0));
endmodule

// File: doc/f_to_d_queue.md
Name: f_to_d_queue

Overview:
- Parametrised successor to the single-entry fetch-to-decode pipeline register.
- A DEPTH-entry FIFO of {pc, inst} pairs between fetch and decode.
- Valid/ready handshake on both sides: decode stalls back-pressure the queue without ever dropping fetch.
- Single-cycle flush discards all in-flight instructions on redirect (branch or jump).

Parameters:
- XLEN, 32, instruction width.
- PC_BITS, 5, program-counter width.
- DEPTH, 4, queue entries; power of two, ≥2.
- NOP_INST, 32'h00000013, value driven on D_inst when no instruction is valid; width XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all queued entries.
- F_valid  in  1  fetch presents an instruction.
- F_pc  in  PC_BITS  fetched PC.
- F_inst  in  XLEN  fetched instruction.
- F_ready  out  1  queue can accept this cycle.
- stall_D  in  1  decode cannot consume; acts as inverted ready.
- D_valid  out  1  head entry valid.
- D_pc  out  PC_BITS  head PC.
- D_inst  out  XLEN  head instruction.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset: asynchronous on rst_n low.
  - Pointers and count go to 0; D_valid=0; D_pc=0; D_inst=NOP_INST; F_ready=1.
  - Reset asserted mid-operation drops all entries immediately.
  - First accept is possible in the first edge after rst_n is released.
- Derived signals:
  - push = F_valid & F_ready.
  - pop = D_valid & !stall_D.
  - F_ready = (count != DEPTH). It is registered-state-only with no combinational path from stall_D, so F_ready is 0 when full even if a pop occurs that cycle.
- Latency: an entry pushed at edge N is visible on D_* after edge N (one-cycle minimum latency). There is no same-cycle bypass.
- Outputs: D_valid = (count != 0). D_pc/D_inst come from the head entry when D_valid=1; otherwise D_pc=0 and D_inst=NOP_INST.
- Per-edge update, priority order:
  - flush: rd_ptr, wr_ptr and count go to 0. Any concurrent push or pop is ignored, so an F_valid instruction in the flush cycle is discarded.
  - push & pop: write at wr_ptr, advance both pointers, count unchanged. This only occurs when 0<count<DEPTH.
  - push only: write, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count-1.
  - Otherwise hold. With stall_D=1 and no push, all state and outputs are stable.
- Pointers: $clog2(DEPTH) bits, wrapping naturally modulo DEPTH.
- Storage: data storage is not reset; only control state is.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Invariants, asserted in simulation:
  - count ≤ DEPTH.
  - No push when count==DEPTH.
  - No pop when count==0.

Decomposition:
- Shared package (pipe_pkg):
  - NOP_INST constant.
  - fd_entry_t struct {pc, inst}, parametrised via package-level XLEN/PC_BITS constants.
- Sub-module fd_queue_mem: DEPTH×(PC_BITS+XLEN) register array with one write port and one asynchronous read port.
- All pointer, count and flush control stays in f_to_d_queue.

Test Plan:
- Reset: hold rst_n=0 with F_valid=1 → D_valid=0, D_inst=32'h00000013, count=0, F_ready=1. Release rst_n, push pc=1 → D_valid=1 and D_pc=1 on the next cycle.
- Fill: stall_D=1, push pc=1..4 with insts A..D → count=4 and F_ready=0. A 5th F_valid is not accepted and D_pc stays 1. Release stall_D → D_pc sequence 1,2,3,4 over four cycles, then D_valid=0.
- Streaming: F_valid=1 continuously, stall_D=0, pc 0..31 → each instruction appears exactly one cycle after acceptance and count stays 1. This exercises pointer wrap-around eight times.
- Simultaneous push/pop at count=2 → count stays 2 and output order is preserved.
- Flush: with count=3, assert flush together with F_valid=1 (pc=9) → next cycle count=0, D_valid=0, and pc 9 never appears at the output. The following push of pc=10 appears next.
- Async reset mid-stream: drop rst_n between clock edges with count=3 → D_valid falls without waiting for a clock edge, and queue contents are lost.
